// File: rtl/cpu_pkg.sv
// Shared CPU core types: fixed widths, memory access size encodings, the
// memory-stage FSM states and the captured instruction payload.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned STRB_W = XLEN / 8;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              rf_we;
        logic [REG_AW-1:0] rf_waddr;
        logic [XLEN-1:0]   rf_wdata;
        logic              mem_en;
        logic              mem_we;
        logic [1:0]        mem_size;
        logic              mem_unsigned;
        logic [XLEN-1:0]   mem_wdata;
    } ms_bits_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for data memory: store strobes and lane replication,
// plus load shifting and zero/sign extension. Purely combinational.
module mem_align
    import cpu_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   ld_data
);

    logic [XLEN-1:0] shifted;

    // Store side; size 3 falls through to word
    always_comb begin
        wstrb = '1;
        wdata = st_data;
        case (size)
            SZ_B: begin
                wstrb = STRB_W'(4'b0001 << addr_lo);
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                wstrb = STRB_W'(4'b0011 << {addr_lo[1], 1'b0});
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = rdata;
        case (size)
            SZ_B:    shifted = rdata >> {addr_lo, 3'b000};
            SZ_H:    shifted = rdata >> {addr_lo[1], 4'b0000};
            default: ;
        endcase
    end

    always_comb begin
        ld_data = shifted;
        case (size)
            SZ_B: ld_data = is_unsigned ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: ld_data = is_unsigned ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and write-back.
// Optional forwarding outputs are compiled in with MEM_STAGE_FWD_EN.
module mem_stage
    import cpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                ms_valid,
    output logic                ms_ready,
    input  logic [XLEN-1:0]     ms_bits_pc,
    input  logic                ms_bits_rf_we,
    input  logic [REG_AW-1:0]   ms_bits_rf_waddr,
    input  logic [XLEN-1:0]     ms_bits_rf_wdata,
    input  logic                ms_bits_mem_en,
    input  logic                ms_bits_mem_we,
    input  logic [1:0]          ms_bits_mem_size,
    input  logic                ms_bits_mem_unsigned,
    input  logic [XLEN-1:0]     ms_bits_mem_wdata,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic [XLEN-1:0]     dmem_req_addr,
    output logic                dmem_req_we,
    output logic [STRB_W-1:0]   dmem_req_wstrb,
    output logic [XLEN-1:0]     dmem_req_wdata,
    input  logic                dmem_resp_valid,
    input  logic [XLEN-1:0]     dmem_resp_rdata,
    output logic                ws_valid,
    input  logic                ws_ready,
    output logic [XLEN-1:0]     ws_bits_pc,
    output logic                ws_bits_rf_we,
    output logic [REG_AW-1:0]   ws_bits_rf_waddr,
    output logic [XLEN-1:0]     ws_bits_rf_wdata
`ifdef MEM_STAGE_FWD_EN
    ,
    output logic                fwd_valid,
    output logic [REG_AW-1:0]   fwd_waddr,
    output logic                fwd_busy,
    output logic [XLEN-1:0]     fwd_wdata
`endif
);

    state_t            state;
    state_t            state_nxt;
    ms_bits_t          bits_q;
    logic              accept_c;
    logic              load_done_c;
    logic [XLEN-1:0]   req_addr_c;
    logic [STRB_W-1:0] strb_c;
    logic [XLEN-1:0]   rep_c;
    logic [XLEN-1:0]   ld_c;

    assign accept_c    = ms_valid & ms_ready;
    assign load_done_c = (state == WAIT) & dmem_resp_valid;

    mem_align u_align (
        .addr_lo     (bits_q.rf_wdata[1:0]),
        .size        (bits_q.mem_size),
        .is_unsigned (bits_q.mem_unsigned),
        .st_data     (bits_q.mem_wdata),
        .rdata       (dmem_resp_rdata),
        .wstrb       (strb_c),
        .wdata       (rep_c),
        .ld_data     (ld_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; DONE re-accepts in the ws handshake cycle
    always_comb begin
        state_nxt      = state;
        ms_ready       = 1'b0;
        dmem_req_valid = 1'b0;
        ws_valid       = 1'b0;
        case (state)
            IDLE: begin
                ms_ready = 1'b1;
                if (ms_valid) begin
                    state_nxt = ms_bits_mem_en ? REQ : DONE;
                end
            end
            REQ: begin
                dmem_req_valid = bits_q.mem_en;
                if (dmem_req_ready) begin
                    state_nxt = bits_q.mem_we ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_resp_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ws_valid = 1'b1;
                ms_ready = ws_ready;
                if (ws_ready) begin
                    if (ms_valid) begin
                        state_nxt = ms_bits_mem_en ? REQ : DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bits_q <= '0;
        end else if (accept_c) begin
            bits_q <= {ms_bits_pc, ms_bits_rf_we, ms_bits_rf_waddr, ms_bits_rf_wdata,
                       ms_bits_mem_en, ms_bits_mem_we, ms_bits_mem_size,
                       ms_bits_mem_unsigned, ms_bits_mem_wdata};
        end else if (load_done_c) begin
            bits_q.rf_wdata <= ld_c;
        end
    end

    // Misaligned low address bits are dropped to the access size
    always_comb begin
        case (bits_q.mem_size)
            SZ_B:    req_addr_c = bits_q.rf_wdata;
            SZ_H:    req_addr_c = {bits_q.rf_wdata[XLEN-1:1], 1'b0};
            default: req_addr_c = {bits_q.rf_wdata[XLEN-1:2], 2'b00};
        endcase
    end

    assign dmem_req_addr  = dmem_req_valid ? req_addr_c : '0;
    assign dmem_req_we    = dmem_req_valid & bits_q.mem_we;
    assign dmem_req_wstrb = dmem_req_we ? strb_c : '0;
    assign dmem_req_wdata = dmem_req_we ? rep_c : '0;

    assign ws_bits_pc       = bits_q.pc;
    assign ws_bits_rf_we    = bits_q.rf_we;
    assign ws_bits_rf_waddr = bits_q.rf_waddr;
    assign ws_bits_rf_wdata = bits_q.rf_wdata;

`ifdef MEM_STAGE_FWD_EN
    logic in_mem_c;

    // Loads have no usable value until the response, so decode must stall
    assign in_mem_c  = (state == REQ) | (state == WAIT);
    assign fwd_busy  = in_mem_c & bits_q.mem_en & ~bits_q.mem_we;
    assign fwd_valid = bits_q.rf_we & ((state == DONE) | (in_mem_c & bits_q.mem_we));
    assign fwd_waddr = bits_q.rf_waddr;
    assign fwd_wdata = bits_q.rf_wdata;
`endif

endmodule
